// File: rtl/control_sequencer_if.sv
// -----------------------------------------------------------------------------
// control_sequencer_if
//   Bundles the sequencer's program-memory, datapath-control and status
//   signals. Signal names follow the datapath's existing control-port names.
//
//   master : the sequencer (drives ROM address, datapath controls, status)
//   slave  : program ROM + datapath + host (drive start, instrData, dpHalt)
//
//   start             host -> seq   begin execution from address 0
//   instrData[23:0]   ROM  -> seq   ROM read data, one cycle after instrAddr
//   dpHalt            dp   -> seq   registered zero-test result of register A
//   instrAddr, pc     seq  -> ROM   program counter / ROM address
//   writeEnable ... haltCondition   seq -> dp   one-cycle control pulses
//   running, halted, illegal        seq -> host status
// -----------------------------------------------------------------------------
interface control_sequencer_if #(
    parameter int PC_WIDTH = 8
);
    logic                start;
    logic [23:0]         instrData;
    logic                dpHalt;
    logic [PC_WIDTH-1:0] instrAddr;
    logic [PC_WIDTH-1:0] pc;
    logic                writeEnable;
    logic                writeSourceSelect;
    logic                muxASelect;
    logic                muxBSelect;
    logic [7:0]          extInputData;
    logic [3:0]          destAddress;
    logic [3:0]          aAddress;
    logic [3:0]          bAddress;
    logic [3:0]          aluOpCode;
    logic                haltCondition;
    logic                running;
    logic                halted;
    logic                illegal;

    modport master (
        input  start, instrData, dpHalt,
        output instrAddr, pc, writeEnable, writeSourceSelect, muxASelect,
               muxBSelect, extInputData, destAddress, aAddress, bAddress,
               aluOpCode, haltCondition, running, halted, illegal
    );

    modport slave (
        output start, instrData, dpHalt,
        input  instrAddr, pc, writeEnable, writeSourceSelect, muxASelect,
               muxBSelect, extInputData, destAddress, aAddress, bAddress,
               aluOpCode, haltCondition, running, halted, illegal
    );
endinterface

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//   Fetches 24-bit instructions from a synchronous program ROM and turns each
//   one into a single EXECUTE cycle of datapath control pulses. Also runs the
//   conditional-halt handshake with the datapath's registered halt flag.
//
//   Instruction word: [23:20] class, [19:16] aluOp, [15:12] dest,
//                     [11:8] A, [7:4] B, [7:0] imm8
//
//   Ports:
//     clk  : system clock, rising edge
//     rst  : asynchronous reset, active high
//     bus  : control_sequencer_if.master (ROM, datapath controls, status)
//
//   Per-instruction timeline: FETCH (address out) -> DECODE (ROM data valid,
//   latched into IR) -> EXECUTE (controls asserted). HALTZ adds a CHECK cycle
//   in which the datapath's freshly registered zero flag is sampled.
// -----------------------------------------------------------------------------
module control_sequencer #(
    parameter int PC_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    control_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_CHECK,
        ST_HALTED
    } state_t;

    localparam logic [3:0] CL_NOP    = 4'd0;
    localparam logic [3:0] CL_ALU_RR = 4'd1;
    localparam logic [3:0] CL_ALU_RI = 4'd2;
    localparam logic [3:0] CL_ALU_IR = 4'd3;
    localparam logic [3:0] CL_LOADI  = 4'd4;
    localparam logic [3:0] CL_HALTZ  = 4'd5;
    localparam logic [3:0] CL_JMP    = 4'd6;
    localparam logic [3:0] CL_HALT   = 4'd7;

    localparam logic [PC_WIDTH-1:0] PC_ZERO = '0;
    localparam logic [PC_WIDTH-1:0] PC_ONE  = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    state_t              state_reg;
    logic [PC_WIDTH-1:0] pc_reg;
    logic [23:0]         ir_reg;
    logic                running_reg;
    logic                halted_reg;

    // Registered strobes and field enables. They are loaded on the edge that
    // enters EXECUTE and cleared on the edge that leaves it, so every control
    // output is zero outside EXECUTE without any combinational state decode.
    logic we_reg;
    logic wss_reg;
    logic mux_a_reg;
    logic mux_b_reg;
    logic imm_en_reg;
    logic dest_en_reg;
    logic a_en_reg;
    logic b_en_reg;
    logic op_en_reg;
    logic haltc_reg;
    logic illegal_reg;

    logic [3:0]          fetched_class;
    logic [3:0]          ir_class;
    logic [PC_WIDTH-1:0] jump_target;

    assign fetched_class = bus.instrData[23:20];
    assign ir_class      = ir_reg[23:20];

    // JMP target: imm8 zero-extended or truncated to the PC width.
    generate
        if (PC_WIDTH > 8) begin : g_jmp_ext
            assign jump_target = {{(PC_WIDTH-8){1'b0}}, ir_reg[7:0]};
        end else if (PC_WIDTH == 8) begin : g_jmp_eq
            assign jump_target = ir_reg[7:0];
        end else begin : g_jmp_trunc
            assign jump_target = ir_reg[PC_WIDTH-1:0];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            pc_reg      <= PC_ZERO;
            ir_reg      <= 24'h000000;
            running_reg <= 1'b0;
            halted_reg  <= 1'b0;
            we_reg      <= 1'b0;
            wss_reg     <= 1'b0;
            mux_a_reg   <= 1'b0;
            mux_b_reg   <= 1'b0;
            imm_en_reg  <= 1'b0;
            dest_en_reg <= 1'b0;
            a_en_reg    <= 1'b0;
            b_en_reg    <= 1'b0;
            op_en_reg   <= 1'b0;
            haltc_reg   <= 1'b0;
            illegal_reg <= 1'b0;
        end else begin
            // Pulses default low; only the DECODE branch raises them.
            we_reg      <= 1'b0;
            wss_reg     <= 1'b0;
            mux_a_reg   <= 1'b0;
            mux_b_reg   <= 1'b0;
            imm_en_reg  <= 1'b0;
            dest_en_reg <= 1'b0;
            a_en_reg    <= 1'b0;
            b_en_reg    <= 1'b0;
            op_en_reg   <= 1'b0;
            haltc_reg   <= 1'b0;
            illegal_reg <= 1'b0;

            case (state_reg)
                ST_IDLE, ST_HALTED: begin
                    if (bus.start) begin
                        state_reg   <= ST_FETCH;
                        pc_reg      <= PC_ZERO;
                        running_reg <= 1'b1;
                        halted_reg  <= 1'b0;
                    end
                end

                ST_FETCH: begin
                    // instrAddr is pc; the ROM registers its data on this edge.
                    state_reg <= ST_DECODE;
                end

                ST_DECODE: begin
                    ir_reg    <= bus.instrData;
                    state_reg <= ST_EXECUTE;
                    // Only the class selects which enables fire; the field
                    // values themselves are taken from IR during EXECUTE.
                    case (fetched_class)
                        CL_ALU_RR: begin
                            we_reg      <= 1'b1;
                            op_en_reg   <= 1'b1;
                            dest_en_reg <= 1'b1;
                            a_en_reg    <= 1'b1;
                            b_en_reg    <= 1'b1;
                        end
                        CL_ALU_RI: begin
                            we_reg      <= 1'b1;
                            mux_b_reg   <= 1'b1;
                            imm_en_reg  <= 1'b1;
                            op_en_reg   <= 1'b1;
                            dest_en_reg <= 1'b1;
                            a_en_reg    <= 1'b1;
                        end
                        CL_ALU_IR: begin
                            we_reg      <= 1'b1;
                            mux_a_reg   <= 1'b1;
                            imm_en_reg  <= 1'b1;
                            op_en_reg   <= 1'b1;
                            dest_en_reg <= 1'b1;
                            b_en_reg    <= 1'b1;
                        end
                        CL_LOADI: begin
                            we_reg      <= 1'b1;
                            wss_reg     <= 1'b1;
                            imm_en_reg  <= 1'b1;
                            dest_en_reg <= 1'b1;
                        end
                        CL_HALTZ: begin
                            haltc_reg <= 1'b1;
                            a_en_reg  <= 1'b1;
                        end
                        CL_NOP, CL_JMP, CL_HALT: begin
                        end
                        default: begin
                            illegal_reg <= 1'b1;
                        end
                    endcase
                end

                ST_EXECUTE: begin
                    case (ir_class)
                        CL_HALT: begin
                            state_reg   <= ST_HALTED;
                            running_reg <= 1'b0;
                            halted_reg  <= 1'b1;
                        end
                        CL_HALTZ: begin
                            state_reg <= ST_CHECK;
                            pc_reg    <= pc_reg + PC_ONE;
                        end
                        CL_JMP: begin
                            state_reg <= ST_FETCH;
                            pc_reg    <= jump_target;
                        end
                        default: begin
                            state_reg <= ST_FETCH;
                            pc_reg    <= pc_reg + PC_ONE;
                        end
                    endcase
                end

                ST_CHECK: begin
                    // The datapath registered its zero flag on the EXECUTE edge.
                    if (bus.dpHalt) begin
                        state_reg   <= ST_HALTED;
                        running_reg <= 1'b0;
                        halted_reg  <= 1'b1;
                    end else begin
                        state_reg <= ST_FETCH;
                    end
                end

                default: begin
                    state_reg   <= ST_IDLE;
                    running_reg <= 1'b0;
                    halted_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.instrAddr         = pc_reg;
    assign bus.pc                = pc_reg;
    assign bus.writeEnable       = we_reg;
    assign bus.writeSourceSelect = wss_reg;
    assign bus.muxASelect        = mux_a_reg;
    assign bus.muxBSelect        = mux_b_reg;
    assign bus.extInputData      = imm_en_reg  ? ir_reg[7:0]   : 8'h00;
    assign bus.destAddress       = dest_en_reg ? ir_reg[15:12] : 4'h0;
    assign bus.aAddress          = a_en_reg    ? ir_reg[11:8]  : 4'h0;
    assign bus.bAddress          = b_en_reg    ? ir_reg[7:4]   : 4'h0;
    assign bus.aluOpCode         = op_en_reg   ? ir_reg[19:16] : 4'h0;
    assign bus.haltCondition     = haltc_reg;
    assign bus.running           = running_reg;
    assign bus.halted            = halted_reg;
    assign bus.illegal           = illegal_reg;

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Instruction sequencer that drives the register-file/ALU datapath's control inputs.
- Fetches 24-bit instructions from a synchronous program ROM and decodes them into one-cycle datapath control pulses (write enable, mux selects, addresses, ALU opcode, immediate data).
- Sequences the conditional-halt handshake with the datapath's registered halt flag.
- Sits between program memory and the datapath at the top level.

Parameters:
- PC_WIDTH, 8, width of program counter and ROM address; PC wraps modulo 2^PC_WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active high.
- start  in  1  begin execution from address 0; honoured only in IDLE or HALTED.
- instrData  in  24  ROM read data; valid the cycle after instrAddr is presented.
- dpHalt  in  1  registered halt flag from the datapath.
- instrAddr  out  PC_WIDTH  ROM address; equals pc.
- pc  out  PC_WIDTH  current program counter.
- writeEnable  out  1  register-file write strobe.
- writeSourceSelect  out  1  1 = extInputData, 0 = ALU result.
- muxASelect  out  1  1 = immediate on ALU A.
- muxBSelect  out  1  1 = immediate on ALU B.
- extInputData  out  8  immediate value.
- destAddress  out  4  destination register.
- aAddress  out  4  register A address.
- bAddress  out  4  register B address.
- aluOpCode  out  4  ALU operation.
- haltCondition  out  1  request for datapath zero-test of register A.
- running  out  1  high in FETCH, DECODE, EXECUTE and CHECK.
- halted  out  1  high in HALTED.
- illegal  out  1  one-cycle pulse in EXECUTE for an undefined class.

Behaviour:
- Instruction fields:
  - [23:20] class
  - [19:16] aluOp
  - [15:12] dest
  - [11:8] A
  - [7:4] B
  - [7:0] imm8
- Classes and the controls they assert in EXECUTE:
  - 0 NOP: none.
  - 1 ALU_RR: writeEnable=1, both muxes 0.
  - 2 ALU_RI: writeEnable=1, muxBSelect=1, extInputData=imm8.
  - 3 ALU_IR: writeEnable=1, muxASelect=1, extInputData=imm8.
  - 4 LOADI: writeEnable=1, writeSourceSelect=1, extInputData=imm8.
  - 5 HALTZ: haltCondition=1, aAddress=A.
  - 6 JMP: pc<=imm8, zero-extended or truncated to PC_WIDTH.
  - 7 HALT: unconditional stop.
  - 8-15: behave as NOP and pulse illegal.
- Output gating:
  - All datapath control outputs are 0 outside EXECUTE.
  - In EXECUTE, address, aluOp and immediate fields come from the latched instruction register (IR), never from instrData.
- States: IDLE, FETCH, DECODE, EXECUTE, CHECK, HALTED.
- Reset: state=IDLE, pc=0, IR=0, all outputs 0.
- Transitions:
  - IDLE --start--> FETCH with pc=0.
  - FETCH drives instrAddr=pc, then -> DECODE.
  - DECODE latches IR<=instrData, then -> EXECUTE.
  - EXECUTE:
    - HALT -> HALTED, pc unchanged.
    - HALTZ -> CHECK, pc+1.
    - JMP -> FETCH, pc=imm8.
    - all others -> FETCH, pc+1.
  - CHECK samples dpHalt (updated by the EXECUTE edge): 1 -> HALTED, 0 -> FETCH.
  - HALTED --start--> FETCH with pc=0; otherwise hold.
- Latency:
  - 3 cycles per instruction; HALTZ takes 4.
  - writeEnable is high for exactly one cycle per writing instruction.
- Boundaries:
  - start while running is ignored.
  - pc at 2^PC_WIDTH-1 increments to 0.
  - JMP to its own address loops indefinitely.
  - dpHalt is ignored outside CHECK.
  - rst in any state forces IDLE within the same cycle (asynchronous), pc=0, controls 0.
  - start coincident with rst deassertion takes effect on the first clock edge after rst low.

Test Plan:
- Reset then start; ROM[0]=LOADI dest=3 imm=0x2A (0x40302A) -> writeEnable one cycle at cycle 3 after start, writeSourceSelect=1, destAddress=3, extInputData=0x2A; pc=1.
- ALU_RR at addr 1, aluOp=2, dest=4, A=3, B=3 (0x124330) -> EXECUTE shows aluOpCode=2, aAddress=3, bAddress=3, both muxes 0, writeEnable pulse.
- HALTZ A=5 with dpHalt driven 1 in CHECK -> haltCondition one cycle, halted=1 at cycle 4, running=0; repeat with dpHalt=0 -> fetch continues at pc+1.
- JMP imm=0x10 at addr 2 -> next instrAddr=0x10; PC_WIDTH=4 build -> JMP 0x1F lands at 0xF, then wraps to 0.
- Class 0xB at any address -> illegal pulses one cycle, no control asserted, pc+1; start asserted mid-run is ignored.
- rst asserted during EXECUTE of ALU_RR -> writeEnable drops immediately, state IDLE, pc=0; no further fetch until start.
